// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for 80x86 DIV / IDIV.
//
// Sequence: IDLE -> SETUP -> DIVIDE (N cycles) -> FIXUP -> IDLE, N = 8 or 16.
// Operands are captured as sign + magnitude when the start is accepted, the
// magnitudes are divided with a restoring shift/subtract loop, and the signs
// are reapplied on the way out. Results, error and the complete pulse are
// registered, so they are stable for the whole FIXUP cycle.
//
// Optional feature: define DIVIDER_EARLY_EXIT_EN to let SETUP report a zero
// divisor or an unsigned-magnitude overflow immediately (complete at cycle 2)
// instead of running the full divide. Signed-range errors always take the
// full latency. With the macro undefined every divide takes N+2 cycles.

module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        complete,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_FIXUP
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e      state_q;
    logic        is8_q;        // operation width is 8 bits
    logic        sgn_q;        // IDIV
    logic        dvd_neg_q;    // dividend was negative
    logic        dvs_neg_q;    // divisor was negative
    logic [31:0] dvd_mag_q;    // dividend magnitude (only [15:0] used for 8-bit)
    logic [15:0] dvs_mag_q;    // divisor magnitude (upper byte zero for 8-bit)
    logic [15:0] rem_q;        // partial remainder
    logic [15:0] quo_q;        // shift register: dividend low half in, quotient out
    logic [3:0]  cnt_q;        // DIVIDE steps remaining minus one
    logic        dz_q;         // divisor magnitude was zero
    logic        ovf_q;        // upper dividend magnitude >= divisor magnitude
    logic [15:0] quotient_q;
    logic [15:0] remainder_q;
    logic        busy_q;
    logic        complete_q;
    logic        error_q;

    // ------------------------------------------------------------------
    // Operand capture: two's-complement negations of the raw inputs
    // ------------------------------------------------------------------
    logic [31:0] neg_dvd32;
    logic [15:0] neg_dvd16;
    logic [15:0] neg_dvs16;
    logic [7:0]  neg_dvs8;

    assign neg_dvd32 = ~dividend + 32'd1;
    assign neg_dvd16 = ~dividend[15:0] + 16'd1;
    assign neg_dvs16 = ~divisor + 16'd1;
    assign neg_dvs8  = ~divisor[7:0] + 8'd1;

    logic        in_dvd_neg;
    logic        in_dvs_neg;
    logic [31:0] in_dvd_mag;
    logic [15:0] in_dvs_mag;

    // Split the incoming operands into sign and magnitude for the selected width.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        in_dvd_neg = 1'b0;
        in_dvs_neg = 1'b0;
        in_dvd_mag = dividend;
        in_dvs_mag = divisor;
        if (is_8_bit) begin
            // The 8-bit dividend is AX (16 bits), the divisor is r8.
            in_dvd_mag = {16'h0000, dividend[15:0]};
            in_dvs_mag = {8'h00, divisor[7:0]};
            if (is_signed) begin
                in_dvd_neg = dividend[15];
                in_dvs_neg = divisor[7];
                if (dividend[15]) in_dvd_mag = {16'h0000, neg_dvd16};
                if (divisor[7])   in_dvs_mag = {8'h00, neg_dvs8};
            end
        end else if (is_signed) begin
            in_dvd_neg = dividend[31];
            in_dvs_neg = divisor[15];
            if (dividend[31]) in_dvd_mag = neg_dvd32;
            if (divisor[15])  in_dvs_mag = neg_dvs16;
        end
    end

    // ------------------------------------------------------------------
    // SETUP checks on the captured magnitudes
    // ------------------------------------------------------------------
    logic [15:0] upper_mag;
    logic [15:0] lower_mag;
    logic        setup_dz;
    logic        setup_ovf;

    assign upper_mag = is8_q ? {8'h00, dvd_mag_q[15:8]} : dvd_mag_q[31:16];
    assign lower_mag = is8_q ? {8'h00, dvd_mag_q[7:0]}  : dvd_mag_q[15:0];
    assign setup_dz  = (dvs_mag_q == 16'h0000);
    // A quotient magnitude that does not fit in N bits shows up as the upper
    // half already being at least the divisor; this also covers a zero divisor.
    assign setup_ovf = (upper_mag >= dvs_mag_q);

    // ------------------------------------------------------------------
    // One restoring step: shift {rem,q} left, trial subtract on N+1 bits
    // ------------------------------------------------------------------
    logic [16:0] shifted;
    logic        fits;
    logic [15:0] diff;
    logic [15:0] rem_d;
    logic [15:0] quo_d;

    // Compute the next partial remainder and quotient shift register.
    always_comb begin
        if (is8_q) shifted = {8'h00, rem_q[7:0], quo_q[7]};
        else       shifted = {rem_q, quo_q[15]};
        fits = (shifted >= {1'b0, dvs_mag_q});
        // When the divisor fits, the difference is below the divisor and so
        // fits in the low 16 bits.
        diff = shifted[15:0] - dvs_mag_q;
        if (is8_q) begin
            rem_d = fits ? {8'h00, diff[7:0]} : {8'h00, shifted[7:0]};
            quo_d = {8'h00, quo_q[6:0], fits};
        end else begin
            rem_d = fits ? diff : shifted[15:0];
            quo_d = {quo_q[14:0], fits};
        end
    end

    // ------------------------------------------------------------------
    // Sign fixup and error decision, applied to the result of the last step
    // ------------------------------------------------------------------
    logic [15:0] max_pos;
    logic        fix_err;
    logic [15:0] q_signed;
    logic [15:0] r_signed;
    logic [15:0] fix_quo;
    logic [15:0] fix_rem;

    // Reapply signs, enforce the signed range and mask to the operation width.
    always_comb begin
        max_pos  = is8_q ? 16'h007F : 16'h7FFF;
        // The 8086 rejects -2^(N-1) as a quotient, so the range is symmetric.
        fix_err  = dz_q | ovf_q | (sgn_q & (quo_d > max_pos));
        q_signed = (dvd_neg_q ^ dvs_neg_q) ? (~quo_d + 16'd1) : quo_d;
        // Remainder follows the dividend sign; negating zero stays zero.
        r_signed = dvd_neg_q ? (~rem_d + 16'd1) : rem_d;
        if (is8_q) begin
            q_signed = {8'h00, q_signed[7:0]};
            r_signed = {8'h00, r_signed[7:0]};
        end
        fix_quo = fix_err ? 16'h0000 : q_signed;
        fix_rem = fix_err ? 16'h0000 : r_signed;
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    // The sign fixup is folded into the edge that ends the last DIVIDE cycle,
    // so in FIXUP the registered results and the complete pulse are already
    // visible and the state only has to release busy.
    // Sequence the divide and register every output.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            is8_q       <= 1'b0;
            sgn_q       <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dvd_mag_q   <= 32'h0;
            dvs_mag_q   <= 16'h0;
            rem_q       <= 16'h0;
            quo_q       <= 16'h0;
            cnt_q       <= 4'd0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= 16'h0;
            remainder_q <= 16'h0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is8_q     <= is_8_bit;
                        sgn_q     <= is_signed;
                        dvd_neg_q <= in_dvd_neg;
                        dvs_neg_q <= in_dvs_neg;
                        dvd_mag_q <= in_dvd_mag;
                        dvs_mag_q <= in_dvs_mag;
                        busy_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    rem_q <= upper_mag;
                    quo_q <= lower_mag;
                    cnt_q <= is8_q ? 4'd7 : 4'd15;
                    dz_q  <= setup_dz;
                    ovf_q <= setup_ovf;
`ifdef DIVIDER_EARLY_EXIT_EN
                    if (setup_dz || setup_ovf) begin
                        quotient_q  <= 16'h0;
                        remainder_q <= 16'h0;
                        error_q     <= 1'b1;
                        complete_q  <= 1'b1;
                        state_q     <= S_FIXUP;
                    end else begin
                        state_q <= S_DIVIDE;
                    end
`else
                    state_q <= S_DIVIDE;
`endif
                end

                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        quotient_q  <= fix_quo;
                        remainder_q <= fix_rem;
                        error_q     <= fix_err;
                        complete_q  <= 1'b1;
                        state_q     <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    // A start seen here coincides with complete and is dropped.
                    complete_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign complete  = complete_q;
    assign error     = error_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider.
// Directed vectors cover the documented examples and range boundaries;
// random operations are compared against an arithmetic reference model.
// Expected latencies follow DIVIDER_EARLY_EXIT_EN when it is defined.

module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIVIDER_EARLY_EXIT_EN
    localparam int EARLY_EXIT = 1;
`else
    localparam int EARLY_EXIT = 0;
`endif
    localparam int Z8  = EARLY_EXIT ? 2 : 10;
    localparam int Z16 = EARLY_EXIT ? 2 : 18;

    seq_divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_8_bit  (is_8_bit),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        b8;
        logic        sg;
        logic [31:0] dd;
        logic [15:0] dv;
        int          stray;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ee;
        int          elat;
    } vec_t;

    // Reference model: plain integer division with truncation toward zero.
    task automatic model(input logic b8, input logic sg, input logic [31:0] dd,
                         input logic [15:0] dv, output logic [15:0] q,
                         output logic [15:0] r, output logic e, output int lat);
        longint a, b, qq, rr, lim, mag, mask;
        int n;
        n = b8 ? 8 : 16;
        if (b8) begin
            a = sg ? longint'($signed(dd[15:0])) : longint'(dd[15:0]);
            b = sg ? longint'($signed(dv[7:0]))  : longint'(dv[7:0]);
        end else begin
            a = sg ? longint'($signed(dd)) : longint'(dd);
            b = sg ? longint'($signed(dv)) : longint'(dv);
        end
        mask = (longint'(1) << n) - 1;
        if (b == 0) begin
            e = 1'b1; qq = 0; rr = 0;
        end else begin
            qq = a / b;
            rr = a % b;
            if (sg) begin
                lim = (longint'(1) << (n - 1)) - 1;
                e = (qq > lim) || (qq < -lim);
            end else begin
                e = (qq > mask);
            end
        end
        mag = (qq < 0) ? -qq : qq;
        q = e ? 16'h0 : 16'(qq & mask);
        r = e ? 16'h0 : 16'(rr & mask);
        lat = n + 2;
        if (EARLY_EXIT != 0 && (b == 0 || mag > mask)) lat = 2;
    endtask

    // Issue one divide from a negedge; optionally pulse start again at cycle
    // 'stray'. Returns at the negedge of the first cycle after complete.
    task automatic run_div(input logic b8, input logic sg, input logic [31:0] dd,
                           input logic [15:0] dv, input int stray,
                           output logic [15:0] oq, output logic [15:0] orm,
                           output logic oe, output int lat,
                           output logic busy_ok, output logic tail_ok);
        int cyc;
        oq = 'x; orm = 'x; oe = 'x;
        lat = 0;
        busy_ok = 1'b1;
        is_8_bit = b8; is_signed = sg; dividend = dd; divisor = dv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs to prove the operands were latched.
        is_8_bit = 1'($urandom); is_signed = 1'($urandom);
        dividend = $urandom; divisor = 16'($urandom);
        cyc = 1;
        while (lat == 0 && cyc <= 40) begin
            start = (cyc == stray);
            if (start) begin
                dividend = $urandom;
                divisor  = 16'($urandom);
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (complete === 1'b1) begin
                lat = cyc;
                oq = quotient; orm = remainder; oe = error;
            end else begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tail_ok = (busy === 1'b0) && (complete === 1'b0) && (quotient === oq) &&
                  (remainder === orm) && (error === oe);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h1; divisor = 16'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete got=%b exp=0", complete); end
        n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
        n_tests++; if (quotient !== 16'h0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0000", quotient); end
        n_tests++; if (remainder !== 16'h0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0000", remainder); end
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vectors(input string tag, input vec_t tab[]);
        logic [15:0] oq, orm;
        logic oe, bok, tok;
        int lat;
        foreach (tab[i]) begin
            run_div(tab[i].b8, tab[i].sg, tab[i].dd, tab[i].dv, tab[i].stray,
                    oq, orm, oe, lat, bok, tok);
            n_tests++;
            if (lat != tab[i].elat) begin
                n_fail++; $display("FAIL %s[%0d] latency got=%0d exp=%0d", tag, i, lat, tab[i].elat);
            end
            n_tests++;
            if (oq !== tab[i].eq) begin
                n_fail++; $display("FAIL %s[%0d] quotient got=%h exp=%h", tag, i, oq, tab[i].eq);
            end
            n_tests++;
            if (orm !== tab[i].er) begin
                n_fail++; $display("FAIL %s[%0d] remainder got=%h exp=%h", tag, i, orm, tab[i].er);
            end
            n_tests++;
            if (oe !== tab[i].ee) begin
                n_fail++; $display("FAIL %s[%0d] error got=%b exp=%b", tag, i, oe, tab[i].ee);
            end
            n_tests++;
            if (bok !== 1'b1) begin
                n_fail++; $display("FAIL %s[%0d] busy_during got=%b exp=1", tag, i, bok);
            end
            n_tests++;
            if (tok !== 1'b1) begin
                n_fail++; $display("FAIL %s[%0d] after_complete (idle, hold) got=%b exp=1", tag, i, tok);
            end
        end
    endtask

    task automatic test_directed();
        vec_t tab[];
        tab = new[13];
        tab[0]  = '{1'b0, 1'b0, 32'h0001_0000, 16'h0002, 0, 16'h8000, 16'h0000, 1'b0, 18};
        tab[1]  = '{1'b1, 1'b0, 32'h0000_0064, 16'h0007, 0, 16'h000E, 16'h0002, 1'b0, 10};
        tab[2]  = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 0, 16'h00F2, 16'h00FE, 1'b0, 10};
        tab[3]  = '{1'b0, 1'b0, 32'h1234_5678, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1, Z16};
        tab[4]  = '{1'b0, 1'b1, 32'hFFFF_8000, 16'h0001, 5, 16'h0000, 16'h0000, 1'b1, 18};
        tab[5]  = '{1'b0, 1'b1, 32'hFFFF_8001, 16'h0001, 5, 16'h8001, 16'h0000, 1'b0, 18};
        tab[6]  = '{1'b1, 1'b0, 32'hDEAD_0064, 16'hBE07, 0, 16'h000E, 16'h0002, 1'b0, 10};
        tab[7]  = '{1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 0, 16'h0000, 16'h0000, 1'b1, 10};
        tab[8]  = '{1'b1, 1'b1, 32'h0000_007F, 16'h00FF, 0, 16'h0081, 16'h0000, 1'b0, 10};
        tab[9]  = '{1'b1, 1'b0, 32'h0000_0700, 16'h0007, 0, 16'h0000, 16'h0000, 1'b1, Z8};
        tab[10] = '{1'b0, 1'b1, 32'h0000_0064, 16'hFFF9, 0, 16'hFFF2, 16'h0002, 1'b0, 18};
        tab[11] = '{1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 0, 16'hFFFF, 16'hFFFE, 1'b0, 18};
        tab[12] = '{1'b0, 1'b1, 32'h8000_0000, 16'hFFFF, 0, 16'h0000, 16'h0000, 1'b1, Z16};
        run_vectors("directed", tab);
    endtask

    // A start raised during the complete cycle must be dropped, and the next
    // start in the first idle cycle must be accepted.
    task automatic test_back_to_back();
        vec_t tab[];
        tab = new[4];
        tab[0] = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 10,  16'h00F2, 16'h00FE, 1'b0, 10};
        tab[1] = '{1'b0, 1'b0, 32'h0001_0000, 16'h0002, 18,  16'h8000, 16'h0000, 1'b0, 18};
        tab[2] = '{1'b0, 1'b0, 32'h0000_0005, 16'h0000, Z16, 16'h0000, 16'h0000, 1'b1, Z16};
        tab[3] = '{1'b1, 1'b0, 32'h0000_00FF, 16'h0010, 3,   16'h000F, 16'h000F, 1'b0, 10};
        run_vectors("b2b", tab);
    endtask

    task automatic test_reset_mid_divide();
        logic [15:0] oq, orm;
        logic oe, bok, tok, saw_complete;
        int lat;
        is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h0001_0000; divisor = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        // Now in cycle 6: reset is sampled at edge 6.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        n_tests++; if (complete !== 1'b0) begin n_fail++; $display("FAIL midreset_complete got=%b exp=0", complete); end
        n_tests++; if (quotient !== 16'h0) begin n_fail++; $display("FAIL midreset_quotient got=%h exp=0000", quotient); end
        n_tests++; if (remainder !== 16'h0) begin n_fail++; $display("FAIL midreset_remainder got=%h exp=0000", remainder); end
        reset = 1'b0;
        saw_complete = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (complete !== 1'b0 || busy !== 1'b0) saw_complete = 1'b1;
        end
        n_tests++;
        if (saw_complete !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_complete got=%b exp=0", saw_complete);
        end
        run_div(1'b0, 1'b0, 32'h0001_0000, 16'h0002, 0, oq, orm, oe, lat, bok, tok);
        n_tests++; if (lat != 18) begin n_fail++; $display("FAIL midreset_restart_latency got=%0d exp=18", lat); end
        n_tests++; if (oq !== 16'h8000) begin n_fail++; $display("FAIL midreset_restart_quotient got=%h exp=8000", oq); end
        n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL midreset_restart_error got=%b exp=0", oe); end
    endtask

    task automatic test_random();
        logic [15:0] oq, orm, eq, er;
        logic oe, ee, bok, tok, b8, sg;
        logic [31:0] dd;
        logic [15:0] dv;
        int lat, elat, stray;
        for (int i = 0; i < 300; i++) begin
            b8 = 1'($urandom);
            sg = 1'($urandom);
            dd = $urandom;
            dv = 16'($urandom);
            case ($urandom_range(0, 4))
                0: ;
                1: dd = dd >> $urandom_range(0, 31);
                2: dd = ~(dd >> $urandom_range(0, 31)) + 32'd1;
                3: dv = 16'($urandom_range(0, 3));
                default: begin
                    dd = dd >> $urandom_range(8, 31);
                    dv = 16'(dv >> $urandom_range(0, 15));
                end
            endcase
            stray = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 18) : 0;
            model(b8, sg, dd, dv, eq, er, ee, elat);
            run_div(b8, sg, dd, dv, stray, oq, orm, oe, lat, bok, tok);
            n_tests++;
            if (oq !== eq || orm !== er || oe !== ee) begin
                n_fail++;
                $display("FAIL random[%0d] b8=%b sg=%b dd=%h dv=%h got q=%h r=%h e=%b exp q=%h r=%h e=%b",
                         i, b8, sg, dd, dv, oq, orm, oe, eq, er, ee);
            end
            n_tests++;
            if (lat != elat) begin
                n_fail++; $display("FAIL random[%0d] latency got=%0d exp=%0d", i, lat, elat);
            end
            n_tests++;
            if (bok !== 1'b1 || tok !== 1'b1) begin
                n_fail++; $display("FAIL random[%0d] handshake busy=%b after=%b exp=1,1", i, bok, tok);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        is_8_bit = 1'b0; is_signed = 1'b0; dividend = 32'h0; divisor = 16'h0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_divide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider executing DIV and IDIV for the 80x86 core. It sits beside the combinational ALU on the microcode datapath and shares its op encoding for ALUOp_DIV/ALUOp_IDIV. The microcode sequencer starts it, stalls on `busy`, then writes quotient and remainder back, or raises INT 0 on `error`.

## Interface
- No parameters; widths fixed by the 8086 ISA.
- `clk` input 1: core clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: accept a new divide; sampled only in IDLE.
- `is_8_bit` input 1: 1 means AX / r8 (dividend[15:0], divisor[7:0]); 0 means DX:AX / r16.
- `is_signed` input 1: 1 means IDIV, 0 means DIV.
- `dividend` input 32: {DX,AX}; bits [31:16] ignored when `is_8_bit`.
- `divisor` input 16: bits [15:8] ignored when `is_8_bit`.
- `quotient` output 16: result; when `is_8_bit`, [7:0] valid and [15:8] zero.
- `remainder` output 16: as above.
- `busy` output 1: high from the cycle after `start` until the `complete` cycle inclusive.
- `complete` output 1: single-cycle pulse; results and `error` valid.
- `error` output 1: divide error (zero divisor or quotient out of range); qualified by `complete`.

## Operation
- States: IDLE → SETUP → DIVIDE → FIXUP → IDLE.
- IDLE: `start` latches operands, mode and sign. Magnitudes are taken when signed. N = 8 or 16.
- SETUP (1 cycle): load the partial remainder from the upper dividend half. Load the shift register from the lower half.
- DIVIDE (N cycles): one bit per cycle.
  - Shift {rem,q} left, trial subtract the divisor magnitude with an (N+1)-bit result.
  - Keep the difference and set q bit 0 if non-negative; otherwise restore.
- FIXUP (1 cycle):
  - Quotient sign = dividend sign XOR divisor sign.
  - Remainder sign = dividend sign; zero results are never negative.
  - Assert `complete` and drive outputs.
- Error conditions:
  - divisor magnitude is 0;
  - unsigned: dividend upper half ≥ divisor;
  - signed: quotient magnitude > 2^(N-1)-1. The 8086 rule applies, so quotient −2^(N-1) is an error.
- On error, `quotient`/`remainder` are 0.
- Outputs hold their last values until the next `complete`.
- `start` while busy is ignored; there is no queueing.
- `start` in the same cycle as `complete` is ignored. The sequencer re-issues it.

## Timing
- Reset values: state IDLE; `busy` 0, `complete` 0, `error` 0, `quotient` 0x0000, `remainder` 0x0000.
- Reset mid-operation aborts in the next edge with no `complete` pulse.
- Start sampled at edge 0. SETUP is cycle 1, DIVIDE is cycles 2..N+1, FIXUP/`complete` is cycle N+2.
- Latency is therefore 10 cycles for 8-bit and 18 cycles for 16-bit.
- `busy` goes low the cycle after `complete`; a new `start` may be sampled then.

## Configuration
- `DIVIDER_EARLY_EXIT_EN` defined:
  - SETUP checks for a zero divisor and for unsigned overflow on magnitudes (upper half ≥ divisor).
  - On a hit, SETUP goes directly to FIXUP, so `complete`+`error` arrive at cycle 2.
  - Signed-range errors are still detected in FIXUP at full latency.
- Undefined: every divide runs the full N+2 cycles, and all errors are reported in FIXUP with identical result values.

## Test plan
- **16-bit DIV:** 16-bit DIV of 0x0001_0000 / 0x0002 → at cycle 18, `quotient` 0x8000, `remainder` 0x0000, `error` 0; `busy` high cycles 1–18.
- **8-bit DIV:** 8-bit DIV of 0x0064 / 0x07 → at cycle 10, `quotient` 0x000E, `remainder` 0x0002.
- **8-bit IDIV:** 8-bit IDIV of 0xFF9C (−100) / 0x07 → `quotient` 0x00F2 (−14), `remainder` 0x00FE (−2).
- **Zero divisor:** 16-bit DIV with divisor 0x0000 → `error` 1, `quotient`/`remainder` 0. `complete` at cycle 2 with `DIVIDER_EARLY_EXIT_EN`, cycle 18 without.
- **Signed range / ignored start:** 16-bit IDIV of 0xFFFF_8000 (−32768) / 0x0001 → `error` 1 at cycle 18. 16-bit IDIV of 0xFFFF_8001 / 0x0001 → `quotient` 0x8001, `error` 0. A `start` pulsed at cycle 5 during either divide is ignored.
- **Reset mid-divide:** `reset` at cycle 6 of a 16-bit divide → next cycle `busy` 0, outputs 0, no `complete`. A fresh `start` then completes normally 18 cycles later.
